// File: rtl/pulse_seq_n.sv
// Multi-channel pulse sequencer: one period counter, NCH delay/width/repeat/spacing
// channels, sync marker, receiver inhibit, and double-buffered config with deferred commit.
// Ports: clk, resetn (sync, active low); cfg_wr/cfg_ch/cfg_field/cfg_data write shadow fields;
// per_in/cfg_commit request a shadow->active transfer; run, block;
// sync_out, pulse_out[NCH], inhib, pending.
module pulse_seq_n #(
  parameter int NCH      = 4,
  parameter int CW       = 24,
  parameter int PW       = 16,
  parameter int RW       = 8,
  parameter int SYNC_W   = 8,
  parameter int INH_HOLD = 4
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           cfg_wr,
  input  logic [3:0]     cfg_ch,
  input  logic [1:0]     cfg_field,
  input  logic [PW-1:0]  cfg_data,
  input  logic [CW-1:0]  per_in,
  input  logic           cfg_commit,
  input  logic           run,
  input  logic           block,
  output logic           sync_out,
  output logic [NCH-1:0] pulse_out,
  output logic           inhib,
  output logic           pending
);
  localparam int HW = $clog2(INH_HOLD + 2);

  typedef enum logic [2:0] {IDLE, WAIT, ON, GAP, DONE} st_t;

  logic [PW-1:0] del_s_q [NCH], del_s_d [NCH];
  logic [PW-1:0] wid_s_q [NCH], wid_s_d [NCH];
  logic [RW-1:0] rep_s_q [NCH], rep_s_d [NCH];
  logic [PW-1:0] spc_s_q [NCH], spc_s_d [NCH];
  logic [PW-1:0] del_a_q [NCH], del_a_d [NCH];
  logic [PW-1:0] wid_a_q [NCH], wid_a_d [NCH];
  logic [RW-1:0] rep_a_q [NCH], rep_a_d [NCH];
  logic [PW-1:0] spc_a_q [NCH], spc_a_d [NCH];
  st_t           st_q    [NCH], st_d    [NCH];
  logic [RW-1:0] rem_q   [NCH], rem_d   [NCH];
  logic [PW-1:0] ctr_q   [NCH], ctr_d   [NCH];

  logic [CW-1:0]  per_s_q, per_s_d, per_a_q, per_a_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           pending_q, pending_d;
  logic           sync_q, sync_d, inhib_q, inhib_d;
  logic [NCH-1:0] pulse_q, pulse_d;
  logic [HW-1:0]  hold_q, hold_d;

  logic           run_ok, wrap, xfer;
  logic [NCH-1:0] on_v, act_v;
  st_t            cur;
  logic [RW-1:0]  rem;
  logic [PW-1:0]  ctr;

  always_comb begin
    del_s_d = del_s_q;
    wid_s_d = wid_s_q;
    rep_s_d = rep_s_q;
    spc_s_d = spc_s_q;
    del_a_d = del_a_q;
    wid_a_d = wid_a_q;
    rep_a_d = rep_a_q;
    spc_a_d = spc_a_q;
    st_d    = st_q;
    rem_d   = rem_q;
    ctr_d   = ctr_q;
    per_s_d = per_s_q;
    per_a_d = per_a_q;
    cnt_d   = '0;
    on_v    = '0;
    act_v   = '0;
    cur     = IDLE;
    rem     = '0;
    ctr     = '0;

    run_ok = run && (per_a_q >= CW'(2));
    wrap   = run_ok && (cnt_q == per_a_q - CW'(1));
    xfer   = pending_q && (!run_ok || wrap);
    if (run_ok) cnt_d = wrap ? '0 : cnt_q + CW'(1);

    pending_d = cfg_commit | (pending_q & ~xfer);
    if (cfg_commit) per_s_d = per_in;

    // Transfer copies the pre-edge shadow, so a coincident write stays shadow-only.
    if (xfer) begin
      per_a_d = per_s_q;
      del_a_d = del_s_q;
      wid_a_d = wid_s_q;
      rep_a_d = rep_s_q;
      spc_a_d = spc_s_q;
    end

    for (int k = 0; k < NCH; k++) begin
      if (cfg_wr && cfg_ch == 4'(k)) begin
        unique case (cfg_field)
          2'd0: del_s_d[k] = cfg_data;
          2'd1: wid_s_d[k] = cfg_data;
          2'd2: rep_s_d[k] = RW'(cfg_data);
          2'd3: spc_s_d[k] = cfg_data;
        endcase
      end
    end

    for (int k = 0; k < NCH; k++) begin
      cur = st_q[k];
      rem = rem_q[k];
      ctr = ctr_q[k];
      // Every period start re-arms, cutting off any pulse still running.
      if (cnt_q == '0) begin
        cur = WAIT;
        rem = rep_a_q[k];
      end
      st_d[k]  = cur;
      rem_d[k] = rem;
      ctr_d[k] = ctr;
      unique case (cur)
        IDLE, DONE: ;
        WAIT: begin
          if (cnt_q == CW'(del_a_q[k]) &&
              wid_a_q[k] != '0 && rem != '0) begin
            st_d[k]  = ON;
            ctr_d[k] = wid_a_q[k] - PW'(1);
            rem_d[k] = rem - RW'(1);
          end
        end
        ON: begin
          if (ctr != '0) begin
            ctr_d[k] = ctr - PW'(1);
          end else if (rem == '0) begin
            st_d[k] = DONE;
          end else if (spc_a_q[k] == '0) begin
            ctr_d[k] = wid_a_q[k] - PW'(1);
            rem_d[k] = rem - RW'(1);
          end else begin
            st_d[k]  = GAP;
            ctr_d[k] = spc_a_q[k] - PW'(1);
          end
        end
        GAP: begin
          if (ctr != '0) begin
            ctr_d[k] = ctr - PW'(1);
          end else begin
            st_d[k]  = ON;
            ctr_d[k] = wid_a_q[k] - PW'(1);
            rem_d[k] = rem - RW'(1);
          end
        end
        default: st_d[k] = IDLE;
      endcase
      if (!run_ok) begin
        st_d[k]  = IDLE;
        rem_d[k] = '0;
        ctr_d[k] = '0;
      end
      on_v[k]  = (st_d[k] == ON);
      act_v[k] = (st_d[k] == ON) || (st_d[k] == GAP);
    end

    sync_d  = run_ok && (cnt_q < CW'(SYNC_W));
    pulse_d = block ? '0 : on_v;

    // Gaps inside a train keep inhibit up; the hold tail starts after the final pulse.
    if (!run_ok) begin
      inhib_d = 1'b0;
      hold_d  = '0;
    end else if (|act_v) begin
      inhib_d = 1'b1;
      hold_d  = HW'(INH_HOLD);
    end else if (cnt_q == '0 || hold_q == '0) begin
      inhib_d = 1'b0;
      hold_d  = '0;
    end else begin
      inhib_d = 1'b1;
      hold_d  = hold_q - HW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      del_s_q   <= '{default: '0};
      wid_s_q   <= '{default: '0};
      rep_s_q   <= '{default: '0};
      spc_s_q   <= '{default: '0};
      del_a_q   <= '{default: '0};
      wid_a_q   <= '{default: '0};
      rep_a_q   <= '{default: '0};
      spc_a_q   <= '{default: '0};
      st_q      <= '{default: IDLE};
      rem_q     <= '{default: '0};
      ctr_q     <= '{default: '0};
      per_s_q   <= '0;
      per_a_q   <= '0;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      sync_q    <= 1'b0;
      pulse_q   <= '0;
      inhib_q   <= 1'b0;
      hold_q    <= '0;
    end else begin
      del_s_q   <= del_s_d;
      wid_s_q   <= wid_s_d;
      rep_s_q   <= rep_s_d;
      spc_s_q   <= spc_s_d;
      del_a_q   <= del_a_d;
      wid_a_q   <= wid_a_d;
      rep_a_q   <= rep_a_d;
      spc_a_q   <= spc_a_d;
      st_q      <= st_d;
      rem_q     <= rem_d;
      ctr_q     <= ctr_d;
      per_s_q   <= per_s_d;
      per_a_q   <= per_a_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      sync_q    <= sync_d;
      pulse_q   <= pulse_d;
      inhib_q   <= inhib_d;
      hold_q    <= hold_d;
    end
  end

  assign sync_out  = sync_q;
  assign pulse_out = pulse_q;
  assign inhib     = inhib_q;
  assign pending   = pending_q;
endmodule

// File: tb/tb_pulse_seq_n.sv
// Scoreboard bench for pulse_seq_n: a period-level reference model pushes the
// expected outputs per clock; a monitor pops and compares after each edge.
module tb_pulse_seq_n;
  localparam int NCH = 4, CW = 24, PW = 16, RW = 8;
  localparam int SYNC_W = 8, INH_HOLD = 4;

  logic           clk = 0;
  logic           resetn = 0;
  logic           cfg_wr = 0;
  logic [3:0]     cfg_ch = '0;
  logic [1:0]     cfg_field = '0;
  logic [PW-1:0]  cfg_data = '0;
  logic [CW-1:0]  per_in = '0;
  logic           cfg_commit = 0;
  logic           run = 0;
  logic           block = 0;
  logic           sync_out;
  logic [NCH-1:0] pulse_out;
  logic           inhib;
  logic           pending;

  pulse_seq_n #(
    .NCH(NCH), .CW(CW), .PW(PW), .RW(RW),
    .SYNC_W(SYNC_W), .INH_HOLD(INH_HOLD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_field(cfg_field), .cfg_data(cfg_data),
    .per_in(per_in), .cfg_commit(cfg_commit),
    .run(run), .block(block),
    .sync_out(sync_out), .pulse_out(pulse_out),
    .inhib(inhib), .pending(pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           sync;
    logic [NCH-1:0] pulse;
    logic           inh;
    logic           pend;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc_n = 0;

  // Reference model state: config tables plus position within the period.
  longint m_del_s[NCH], m_wid_s[NCH], m_rep_s[NCH], m_spc_s[NCH];
  longint m_del_a[NCH], m_wid_a[NCH], m_rep_a[NCH], m_spc_a[NCH];
  longint m_per_s, m_per_a, m_cnt;
  bit     m_pend;

  function automatic void m_clear();
    for (int k = 0; k < NCH; k++) begin
      m_del_s[k] = 0; m_wid_s[k] = 0; m_rep_s[k] = 0; m_spc_s[k] = 0;
      m_del_a[k] = 0; m_wid_a[k] = 0; m_rep_a[k] = 0; m_spc_a[k] = 0;
    end
    m_per_s = 0; m_per_a = 0; m_cnt = 0; m_pend = 0;
  endfunction

  // Span of the train: first pulse start to last pulse end (gaps included).
  function automatic bit ch_act(int k, longint c);
    longint d = m_del_a[k], w = m_wid_a[k];
    longint r = m_rep_a[k], s = m_spc_a[k];
    if (w == 0 || r == 0 || c < d) return 0;
    return (c - d) < r * (w + s) - s;
  endfunction

  function automatic bit ch_on(int k, longint c);
    longint w = m_wid_a[k], s = m_spc_a[k];
    if (!ch_act(k, c)) return 0;
    return ((c - m_del_a[k]) % (w + s)) < w;
  endfunction

  function automatic void model_step();
    exp_t   e = '0;
    bit     run_ok, wrap, xfer;
    longint c;
    if (!resetn) begin
      m_clear();
      exp_q.push_back(e);
      return;
    end
    run_ok = run && m_per_a >= 2;
    wrap = run_ok && m_cnt == m_per_a - 1;
    if (run_ok) begin
      c = m_cnt;
      e.sync = c < SYNC_W;
      for (int k = 0; k < NCH; k++)
        if (ch_on(k, c)) e.pulse[k] = !block;
      for (int d = 0; d <= INH_HOLD; d++)
        for (int k = 0; k < NCH; k++)
          if (c >= d && ch_act(k, c - d)) e.inh = 1;
      m_cnt = wrap ? 0 : c + 1;
    end else begin
      m_cnt = 0;
    end
    xfer = m_pend && (!run_ok || wrap);
    if (xfer) begin
      m_per_a = m_per_s;
      m_del_a = m_del_s; m_wid_a = m_wid_s;
      m_rep_a = m_rep_s; m_spc_a = m_spc_s;
    end
    if (cfg_wr && cfg_ch < NCH) begin
      case (cfg_field)
        2'd0: m_del_s[cfg_ch] = cfg_data;
        2'd1: m_wid_s[cfg_ch] = cfg_data;
        2'd2: m_rep_s[cfg_ch] = cfg_data & 16'hff;
        default: m_spc_s[cfg_ch] = cfg_data;
      endcase
    end
    if (cfg_commit) m_per_s = per_in;
    m_pend = cfg_commit || (m_pend && !xfer);
    e.pend = m_pend;
    exp_q.push_back(e);
  endfunction

  // One clock: model sees the inputs the DUT will sample on this edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic wr(int ch, int fld, int data);
    cfg_wr = 1; cfg_ch = 4'(ch);
    cfg_field = 2'(fld); cfg_data = PW'(data);
    tick();
    cfg_wr = 0;
  endtask

  task automatic set_ch(int ch, int d, int w, int r, int s);
    wr(ch, 0, d); wr(ch, 1, w); wr(ch, 2, r); wr(ch, 3, s);
  endtask

  task automatic commit(int p);
    cfg_commit = 1; per_in = CW'(p);
    tick();
    cfg_commit = 0;
  endtask

  task automatic wait_cnt(longint c);
    int n = 0;
    while (m_cnt != c && n < 5000) begin tick(); n++; end
    n_chk++;
    if (m_cnt == c) n_pass++;
    else $display("FAIL wait_cnt: cnt %0d never reached (at %0d)", c, m_cnt);
  endtask

  initial begin : monitor
    exp_t e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = '{sync_out, pulse_out, inhib, pending};
        cyc_n++;
        n_chk++;
        if (got === e) n_pass++;
        else $display("FAIL outputs cycle %0d: got sync=%b pulse=%b inhib=%b pend=%b, want sync=%b pulse=%b inhib=%b pend=%b",
                      cyc_n, got.sync, got.pulse, got.inh, got.pend,
                      e.sync, e.pulse, e.inh, e.pend);
      end
    end
  end

  initial begin : stim
    m_clear();
    @(negedge clk);
    resetn = 0; run = 1;
    ticks(5);
    resetn = 1;
    ticks(5);
    run = 0;
    set_ch(0, 10, 5, 1, 0);
    commit(100);
    tick();
    run = 1;
    ticks(250);
    set_ch(1, 20, 4, 3, 6);
    commit(200);
    ticks(450);
    wait_cnt(50);
    wr(0, 0, 30);
    commit(200);
    ticks(400);
    run = 0;
    tick();
    set_ch(0, 5, 0, 1, 0);
    set_ch(1, 70, 5, 1, 0);
    set_ch(2, 60, 10, 1, 0);
    set_ch(3, 5, 3, 2, 2);
    commit(64);
    run = 1;
    ticks(150);
    block = 1;
    ticks(130);
    block = 0;
    set_ch(1, 20, 4, 3, 6);
    commit(200);
    wait_cnt(31);
    resetn = 0;
    tick();
    resetn = 1;
    ticks(50);
    for (int i = 0; i < 4000; i++) begin
      cfg_wr = ($urandom_range(0, 5) == 0);
      cfg_ch = 4'($urandom_range(0, 5));
      cfg_field = 2'($urandom_range(0, 3));
      cfg_data = ($urandom_range(0, 30) == 0) ? PW'($urandom)
                                              : PW'($urandom_range(0, 25));
      cfg_commit = ($urandom_range(0, 60) == 0);
      per_in = CW'($urandom_range(0, 90));
      if ($urandom_range(0, 250) == 0) run = ~run;
      if ($urandom_range(0, 40) == 0) block = ~block;
      resetn = ($urandom_range(0, 1500) != 0);
      tick();
    end
    cfg_wr = 0; cfg_commit = 0; resetn = 1;
    ticks(2);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
